// File: rtl/cpu_defs_pkg.sv
// Pipeline-wide shared types: per-instruction exception/refetch flags carried from EXE/MEM.
package cpu_defs_pkg;

  typedef struct packed {
    logic Interrupt;
    logic WrongAddressinIF;
    logic TLBRefillinIF;
    logic TLBInvalidinIF;
    logic ReservedInstruction;
    logic CoprocessorUnusable;
    logic Syscall;
    logic Break;
    logic Trap;
    logic Overflow;
    logic RdWrongAddressinMEM;
    logic WrWrongAddressinMEM;
    logic RdTLBRefillinMEM;
    logic RdTLBInvalidinMEM;
    logic WrTLBRefillinMEM;
    logic WrTLBInvalidinMEM;
    logic TLBModified;
    logic Eret;
    logic Refetch;
  } ExceptinPipeType;

endpackage

// File: rtl/exc_flush_ctrl_pkg.sv
// MIPS ExcCode values and flush-sequencer state encoding.
package exc_flush_ctrl_pkg;

  localparam logic [4:0] EXCCODE_INT  = 5'd0;
  localparam logic [4:0] EXCCODE_MOD  = 5'd1;
  localparam logic [4:0] EXCCODE_TLBL = 5'd2;
  localparam logic [4:0] EXCCODE_TLBS = 5'd3;
  localparam logic [4:0] EXCCODE_ADEL = 5'd4;
  localparam logic [4:0] EXCCODE_ADES = 5'd5;
  localparam logic [4:0] EXCCODE_SYS  = 5'd8;
  localparam logic [4:0] EXCCODE_BP   = 5'd9;
  localparam logic [4:0] EXCCODE_RI   = 5'd10;
  localparam logic [4:0] EXCCODE_CPU  = 5'd11;
  localparam logic [4:0] EXCCODE_OV   = 5'd12;
  localparam logic [4:0] EXCCODE_TR   = 5'd13;

  typedef enum logic [1:0] {
    FLUSH_IDLE,
    FLUSH_DRAIN,
    FLUSH_FLUSH,
    FLUSH_REDIRECT
  } flushState_t;

endpackage

// File: rtl/exc_priority_enc.sv
// Picks the single highest-priority cause from a MEM-stage exception vector.
// Purely combinational, zero latency; no handshake.
module exc_priority_enc
  import cpu_defs_pkg::*;
  import exc_flush_ctrl_pkg::*;
(
  input  ExceptinPipeType except,
  output logic            hit,
  output logic [4:0]      excCode,
  output logic            isTlbRefill,
  output logic            isIfSide,
  output logic            isEret,
  output logic            isRefetch
);

  always_comb begin
    hit         = 1'b1;
    excCode     = EXCCODE_INT;
    isTlbRefill = 1'b0;
    isIfSide    = 1'b0;
    isEret      = 1'b0;
    isRefetch   = 1'b0;
    if (except.Interrupt) begin
      excCode = EXCCODE_INT;
    end else if (except.WrongAddressinIF) begin
      excCode  = EXCCODE_ADEL;
      isIfSide = 1'b1;
    end else if (except.TLBRefillinIF) begin
      excCode     = EXCCODE_TLBL;
      isIfSide    = 1'b1;
      isTlbRefill = 1'b1;
    end else if (except.TLBInvalidinIF) begin
      excCode  = EXCCODE_TLBL;
      isIfSide = 1'b1;
    end else if (except.ReservedInstruction) begin
      excCode = EXCCODE_RI;
    end else if (except.CoprocessorUnusable) begin
      excCode = EXCCODE_CPU;
    end else if (except.Syscall) begin
      excCode = EXCCODE_SYS;
    end else if (except.Break) begin
      excCode = EXCCODE_BP;
    end else if (except.Trap) begin
      excCode = EXCCODE_TR;
    end else if (except.Overflow) begin
      excCode = EXCCODE_OV;
    end else if (except.RdWrongAddressinMEM) begin
      excCode = EXCCODE_ADEL;
    end else if (except.WrWrongAddressinMEM) begin
      excCode = EXCCODE_ADES;
    end else if (except.RdTLBRefillinMEM || except.RdTLBInvalidinMEM) begin
      excCode     = EXCCODE_TLBL;
      isTlbRefill = except.RdTLBRefillinMEM;
    end else if (except.WrTLBRefillinMEM || except.WrTLBInvalidinMEM) begin
      excCode     = EXCCODE_TLBS;
      isTlbRefill = except.WrTLBRefillinMEM;
    end else if (except.TLBModified) begin
      excCode = EXCCODE_MOD;
    end else if (except.Eret) begin
      isEret = 1'b1;
    end else if (except.Refetch) begin
      isRefetch = 1'b1;
    end else begin
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/exc_flush_ctrl.sv
// Commit-point exception/ERET/refetch sequencer: drain D-side, flush pipe, update CP0, redirect IF.
// Trigger T -> flush_all T+2 -> redirect_valid T+3 (dcache idle); holds redirect until redirect_ready.
module exc_flush_ctrl
  import cpu_defs_pkg::*;
  import exc_flush_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_BASE      = 32'h8000_0000,
  parameter logic [31:0] REFILL_OFFSET = 32'h0000_0000,
  parameter logic [31:0] GENERAL_OFS   = 32'h0000_0180
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid,
  input  ExceptinPipeType mem_except,
  input  logic [31:0]     mem_pc,
  input  logic [31:0]     mem_badvaddr,
  input  logic            mem_in_ds,
  input  logic            cp0_exl,
  input  logic [31:0]     cp0_epc,
  input  logic            dcache_busy,
  input  logic            redirect_ready,
  output logic            stall_req,
  output logic            flush_all,
  output logic            redirect_valid,
  output logic [31:0]     redirect_pc,
  output logic            cp0_exc_we,
  output logic [4:0]      cp0_exccode,
  output logic [31:0]     cp0_epc_wdata,
  output logic            cp0_bd,
  output logic            cp0_bva_we,
  output logic [31:0]     cp0_bva_wdata,
  output logic            cp0_eret
);

  logic        encHit;
  logic [4:0]  encCode;
  logic        encTlbRefill;
  logic        encIfSide;
  logic        encEret;
  logic        encRefetch;
  logic        trigger;
  logic        isExc;
  logic [31:0] excTarget;

  flushState_t state;
  logic        latExc;
  logic        latEret;
  logic        latBva;

  exc_priority_enc uPrioEnc (
    .except      (mem_except),
    .hit         (encHit),
    .excCode     (encCode),
    .isTlbRefill (encTlbRefill),
    .isIfSide    (encIfSide),
    .isEret      (encEret),
    .isRefetch   (encRefetch)
  );

  assign trigger   = mem_valid && encHit;
  assign isExc     = encHit && !encEret && !encRefetch;
  // Refill vector only applies on the first-level miss; nested misses go general.
  assign excTarget = EXC_BASE + ((encTlbRefill && !cp0_exl) ? REFILL_OFFSET : GENERAL_OFS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= FLUSH_IDLE;
      latExc         <= 1'b0;
      latEret        <= 1'b0;
      latBva         <= 1'b0;
      stall_req      <= 1'b0;
      flush_all      <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
      cp0_exc_we     <= 1'b0;
      cp0_exccode    <= 5'h0;
      cp0_epc_wdata  <= 32'h0;
      cp0_bd         <= 1'b0;
      cp0_bva_we     <= 1'b0;
      cp0_bva_wdata  <= 32'h0;
      cp0_eret       <= 1'b0;
    end else begin
      flush_all  <= 1'b0;
      cp0_exc_we <= 1'b0;
      cp0_bva_we <= 1'b0;
      cp0_eret   <= 1'b0;
      case (state)
        FLUSH_IDLE: begin
          if (trigger) begin
            state         <= FLUSH_DRAIN;
            stall_req     <= 1'b1;
            latExc        <= isExc;
            latEret       <= encEret;
            latBva        <= isExc && (encCode >= EXCCODE_MOD) && (encCode <= EXCCODE_ADES);
            cp0_exccode   <= encCode;
            cp0_bd        <= mem_in_ds;
            cp0_epc_wdata <= mem_in_ds ? (mem_pc - 32'd4) : mem_pc;
            cp0_bva_wdata <= encIfSide ? mem_pc : mem_badvaddr;
            redirect_pc   <= isExc ? excTarget : (encEret ? cp0_epc : mem_pc);
          end
        end
        FLUSH_DRAIN: begin
          if (!dcache_busy) begin
            state      <= FLUSH_FLUSH;
            flush_all  <= 1'b1;
            cp0_exc_we <= latExc;
            cp0_bva_we <= latBva;
            cp0_eret   <= latEret;
          end
        end
        FLUSH_FLUSH: begin
          state          <= FLUSH_REDIRECT;
          redirect_valid <= 1'b1;
        end
        FLUSH_REDIRECT: begin
          if (redirect_ready) begin
            state          <= FLUSH_IDLE;
            redirect_valid <= 1'b0;
            stall_req      <= 1'b0;
          end
        end
        default: state <= FLUSH_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// Directed bench for exc_flush_ctrl: drives at negedge, samples at negedge.
module tb_exc_flush_ctrl;
  import cpu_defs_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            mem_valid;
  ExceptinPipeType mem_except;
  logic [31:0]     mem_pc;
  logic [31:0]     mem_badvaddr;
  logic            mem_in_ds;
  logic            cp0_exl;
  logic [31:0]     cp0_epc;
  logic            dcache_busy;
  logic            redirect_ready;
  logic            stall_req;
  logic            flush_all;
  logic            redirect_valid;
  logic [31:0]     redirect_pc;
  logic            cp0_exc_we;
  logic [4:0]      cp0_exccode;
  logic [31:0]     cp0_epc_wdata;
  logic            cp0_bd;
  logic            cp0_bva_we;
  logic [31:0]     cp0_bva_wdata;
  logic            cp0_eret;

  int checks = 0;
  int errors = 0;
  ExceptinPipeType ex;

  always #5 clk = ~clk;

  exc_flush_ctrl dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_except(mem_except),
    .mem_pc(mem_pc), .mem_badvaddr(mem_badvaddr), .mem_in_ds(mem_in_ds),
    .cp0_exl(cp0_exl), .cp0_epc(cp0_epc), .dcache_busy(dcache_busy),
    .redirect_ready(redirect_ready), .stall_req(stall_req), .flush_all(flush_all),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .cp0_exc_we(cp0_exc_we),
    .cp0_exccode(cp0_exccode), .cp0_epc_wdata(cp0_epc_wdata), .cp0_bd(cp0_bd),
    .cp0_bva_we(cp0_bva_we), .cp0_bva_wdata(cp0_bva_wdata), .cp0_eret(cp0_eret)
  );

  // Presents one instruction for a single cycle (T); returns at the negedge of T+1.
  task automatic fire(input ExceptinPipeType e, input logic [31:0] pc,
                      input logic [31:0] bva, input logic ds);
    @(negedge clk);
    mem_valid = 1'b1; mem_except = e; mem_pc = pc; mem_badvaddr = bva; mem_in_ds = ds;
    @(negedge clk);
    mem_valid = 1'b0; mem_except = '0; mem_pc = 32'hdead_beef;
    mem_badvaddr = 32'h5555_aaaa; mem_in_ds = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_valid = 1'b0; mem_except = '0; mem_pc = 32'h0; mem_badvaddr = 32'h0;
    mem_in_ds = 1'b0; cp0_exl = 1'b0; cp0_epc = 32'h0; dcache_busy = 1'b0; redirect_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({stall_req, flush_all, redirect_valid, cp0_exc_we, cp0_bva_we, cp0_eret, cp0_bd} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0", {stall_req, flush_all, redirect_valid,
               cp0_exc_we, cp0_bva_we, cp0_eret, cp0_bd});
    end
    checks++;
    if (redirect_pc !== 32'h0 || cp0_exccode !== 5'h0 || cp0_epc_wdata !== 32'h0 || cp0_bva_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data pc=%h code=%h epc=%h bva=%h want all 0",
               redirect_pc, cp0_exccode, cp0_epc_wdata, cp0_bva_wdata);
    end
  endtask

  task automatic test_overflow;
    ex = '0; ex.Overflow = 1'b1; cp0_exl = 1'b0;
    fire(ex, 32'h8000_1000, 32'h0, 1'b0);
    checks++;
    if (stall_req !== 1'b1 || flush_all !== 1'b0) begin
      errors++; $display("FAIL ovf_t1 stall=%b flush=%b want 1/0", stall_req, flush_all);
    end
    @(negedge clk);
    checks++;
    if (flush_all !== 1'b1 || cp0_exc_we !== 1'b1 || cp0_bva_we !== 1'b0 || cp0_eret !== 1'b0) begin
      errors++; $display("FAIL ovf_t2 flush=%b we=%b bva_we=%b eret=%b want 1/1/0/0",
                         flush_all, cp0_exc_we, cp0_bva_we, cp0_eret);
    end
    checks++;
    if (cp0_exccode !== 5'd12 || cp0_epc_wdata !== 32'h8000_1000 || cp0_bd !== 1'b0) begin
      errors++; $display("FAIL ovf_cp0 code=%0d epc=%h bd=%b want 12/80001000/0",
                         cp0_exccode, cp0_epc_wdata, cp0_bd);
    end
    @(negedge clk);
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0180 || flush_all !== 1'b0) begin
      errors++; $display("FAIL ovf_t3 rv=%b pc=%h flush=%b want 1/80000180/0",
                         redirect_valid, redirect_pc, flush_all);
    end
    @(negedge clk);
    checks++;
    if (redirect_valid !== 1'b0 || stall_req !== 1'b0) begin
      errors++; $display("FAIL ovf_done rv=%b stall=%b want 0/0", redirect_valid, stall_req);
    end
  endtask

  task automatic test_rd_addr;
    ex = '0; ex.RdWrongAddressinMEM = 1'b1;
    fire(ex, 32'h8000_2004, 32'h0000_1002, 1'b1);
    @(negedge clk);
    checks++;
    if (cp0_exccode !== 5'd4 || cp0_epc_wdata !== 32'h8000_2000 || cp0_bd !== 1'b1) begin
      errors++; $display("FAIL adel_cp0 code=%0d epc=%h bd=%b want 4/80002000/1",
                         cp0_exccode, cp0_epc_wdata, cp0_bd);
    end
    checks++;
    if (cp0_bva_we !== 1'b1 || cp0_bva_wdata !== 32'h0000_1002) begin
      errors++; $display("FAIL adel_bva we=%b data=%h want 1/00001002", cp0_bva_we, cp0_bva_wdata);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tlb_refill_if;
    ex = '0; ex.TLBRefillinIF = 1'b1; cp0_exl = 1'b0;
    fire(ex, 32'h0040_0000, 32'h1234_5678, 1'b0);
    @(negedge clk);
    checks++;
    if (cp0_exccode !== 5'd2 || cp0_bva_we !== 1'b1 || cp0_bva_wdata !== 32'h0040_0000) begin
      errors++; $display("FAIL refill_bva code=%0d we=%b bva=%h want 2/1/00400000",
                         cp0_exccode, cp0_bva_we, cp0_bva_wdata);
    end
    @(negedge clk);
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0000) begin
      errors++; $display("FAIL refill_exl0 rv=%b pc=%h want 1/80000000", redirect_valid, redirect_pc);
    end
    @(negedge clk);
    cp0_exl = 1'b1;
    fire(ex, 32'h0040_0000, 32'h1234_5678, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0180) begin
      errors++; $display("FAIL refill_exl1 rv=%b pc=%h want 1/80000180", redirect_valid, redirect_pc);
    end
    @(negedge clk);
    cp0_exl = 1'b0;
  endtask

  task automatic test_refetch;
    ex = '0; ex.Refetch = 1'b1; ex.Overflow = 1'b1;
    fire(ex, 32'h8000_3000, 32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (cp0_exc_we !== 1'b1 || cp0_exccode !== 5'd12) begin
      errors++; $display("FAIL refetch_ovf we=%b code=%0d want 1/12", cp0_exc_we, cp0_exccode);
    end
    @(negedge clk);
    checks++;
    if (redirect_pc !== 32'h8000_0180) begin
      errors++; $display("FAIL refetch_ovf_pc got %h want 80000180", redirect_pc);
    end
    @(negedge clk);
    ex = '0; ex.Refetch = 1'b1;
    fire(ex, 32'h9fc0_0010, 32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (flush_all !== 1'b1 || cp0_exc_we !== 1'b0 || cp0_bva_we !== 1'b0 || cp0_eret !== 1'b0) begin
      errors++; $display("FAIL refetch_pulses flush=%b we=%b bva=%b eret=%b want 1/0/0/0",
                         flush_all, cp0_exc_we, cp0_bva_we, cp0_eret);
    end
    @(negedge clk);
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h9fc0_0010) begin
      errors++; $display("FAIL refetch_pc rv=%b pc=%h want 1/9fc00010", redirect_valid, redirect_pc);
    end
    @(negedge clk);
  endtask

  task automatic test_drain;
    int bad;
    bad = 0;
    dcache_busy = 1'b1;
    ex = '0; ex.Syscall = 1'b1;
    fire(ex, 32'h8000_4000, 32'h0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      if (stall_req !== 1'b1 || flush_all !== 1'b0) bad++;
      if (i == 1) begin
        // A competing instruction while draining must not disturb the latched cause.
        mem_valid = 1'b1; mem_except = '0; mem_except.Overflow = 1'b1; mem_pc = 32'h8000_5000;
      end else begin
        mem_valid = 1'b0; mem_except = '0;
      end
      if (i == 6) dcache_busy = 1'b0;
      else @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL drain_hold %0d bad cycles want 0 (stall must stay 1, flush 0)", bad);
    end
    @(negedge clk);
    checks++;
    if (flush_all !== 1'b1 || cp0_exccode !== 5'd8 || cp0_epc_wdata !== 32'h8000_4000) begin
      errors++; $display("FAIL drain_flush flush=%b code=%0d epc=%h want 1/8/80004000",
                         flush_all, cp0_exccode, cp0_epc_wdata);
    end
    @(negedge clk);
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0180) begin
      errors++; $display("FAIL drain_redir rv=%b pc=%h want 1/80000180", redirect_valid, redirect_pc);
    end
    @(negedge clk);
    checks++;
    if (stall_req !== 1'b0 || redirect_valid !== 1'b0) begin
      errors++; $display("FAIL drain_done stall=%b rv=%b want 0/0", stall_req, redirect_valid);
    end
  endtask

  task automatic test_backpressure_reset_eret;
    int bad;
    bad = 0;
    redirect_ready = 1'b0;
    ex = '0; ex.Break = 1'b1;
    fire(ex, 32'h8000_6000, 32'h0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0180 || stall_req !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL hold_redirect %0d bad cycles want 0", bad);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({stall_req, flush_all, redirect_valid, cp0_exc_we, cp0_bva_we, cp0_eret} !== 6'b0 ||
        redirect_pc !== 32'h0 || cp0_exccode !== 5'h0 || cp0_epc_wdata !== 32'h0) begin
      errors++; $display("FAIL midreset stall=%b rv=%b pc=%h code=%0d want all 0",
                         stall_req, redirect_valid, redirect_pc, cp0_exccode);
    end
    redirect_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (redirect_valid !== 1'b0 || stall_req !== 1'b0) begin
      errors++; $display("FAIL dropped rv=%b stall=%b want 0/0", redirect_valid, stall_req);
    end
    ex = '0; ex.Eret = 1'b1; cp0_epc = 32'hbfc0_0380;
    fire(ex, 32'h8000_7000, 32'h0, 1'b0);
    cp0_epc = 32'h1111_2222;
    @(negedge clk);
    checks++;
    if (cp0_eret !== 1'b1 || cp0_exc_we !== 1'b0 || flush_all !== 1'b1 || cp0_bva_we !== 1'b0) begin
      errors++; $display("FAIL eret_pulse eret=%b we=%b flush=%b bva=%b want 1/0/1/0",
                         cp0_eret, cp0_exc_we, flush_all, cp0_bva_we);
    end
    @(negedge clk);
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'hbfc0_0380 || cp0_eret !== 1'b0) begin
      errors++; $display("FAIL eret_pc rv=%b pc=%h eret=%b want 1/bfc00380/0",
                         redirect_valid, redirect_pc, cp0_eret);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_rd_addr();
    test_tlb_refill_if();
    test_refetch();
    test_drain();
    test_backpressure_reset_eret();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
